framebuffer_plot_writer: RTL and testbench

//  Receiving end of the pixel-plot stream (plot / x / y / color) that the sprite drawers emit.

---
 rtl/framebuffer_plot_writer_pkg.sv | 45 ++++
 rtl/framebuffer_plot_writer_if.sv | 30 +++
 rtl/framebuffer_plot_writer_plot_fifo.sv | 54 +++++
 rtl/framebuffer_plot_writer.sv | 156 +++++++++++++++
 tb/tb_framebuffer_plot_writer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/framebuffer_plot_writer_pkg.sv
// Shared screen geometry, palette, FSM states and plot record for the framebuffer writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package framebuffer_plot_writer_pkg;

    localparam int SCREEN_W   = 320;
    localparam int SCREEN_H   = 240;
    localparam int X_W        = 9;
    localparam int Y_W        = 8;
    localparam int COLOR_W    = 3;
    localparam int ADDR_W     = 17;
    localparam int NUM_PIXELS = SCREEN_W * SCREEN_H;

    localparam logic [COLOR_W-1:0] BLACK   = 3'b000;
    localparam logic [COLOR_W-1:0] BLUE    = 3'b001;
    localparam logic [COLOR_W-1:0] GREEN   = 3'b010;
    localparam logic [COLOR_W-1:0] CYAN    = 3'b011;
    localparam logic [COLOR_W-1:0] RED     = 3'b100;
    localparam logic [COLOR_W-1:0] MAGENTA = 3'b101;
    localparam logic [COLOR_W-1:0] YELLOW  = 3'b110;
    localparam logic [COLOR_W-1:0] WHITE   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } plot_t;

    // y*320 + x built from shifts so no multiplier is needed.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] w_y;
        logic [ADDR_W-1:0] w_x;
        w_y = ADDR_W'(y);
        w_x = ADDR_W'(x);
        return (w_y << 8) + (w_y << 6) + w_x;
    endfunction

endpackage

// File: rtl/framebuffer_plot_writer_if.sv
// Plot stream in, framebuffer write port and status out.
// Latency: n/a (wiring only).
// Backpressure: none; the plot stream has no ready signal.
interface framebuffer_plot_writer_if;
    import framebuffer_plot_writer_pkg::*;

    logic               plot;
    logic [X_W-1:0]     xCoordinate;
    logic [Y_W-1:0]     yCoordinate;
    logic [COLOR_W-1:0] colorToDraw;
    logic               clear;
    logic [COLOR_W-1:0] clear_color;
    logic [ADDR_W-1:0]  mem_addr;
    logic [COLOR_W-1:0] mem_data;
    logic               mem_we;
    logic               busy;
    logic               overflow;
    logic               oob_drop;

    modport master (
        output plot, xCoordinate, yCoordinate, colorToDraw, clear, clear_color,
        input  mem_addr, mem_data, mem_we, busy, overflow, oob_drop
    );

    modport slave (
        input  plot, xCoordinate, yCoordinate, colorToDraw, clear, clear_color,
        output mem_addr, mem_data, mem_we, busy, overflow, oob_drop
    );

endinterface

// File: rtl/framebuffer_plot_writer_plot_fifo.sv
// Small synchronous FIFO for plot records; DEPTH must be a power of two, at least 2.
// Latency: pushed entry visible at o_pop_dat the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module framebuffer_plot_writer_plot_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_pop_dat = r_mem[r_rd_ptr];

    always_ff @(posedge i_clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/framebuffer_plot_writer.sv
// Plot-stream to framebuffer writer with full-screen clear sweep; PLOT_BOUNDS_CHECK_EN drops off-screen plots.
// Latency: plot to mem_we 2 cycles when idle; one write per clock sustained.
// Backpressure: none upstream; plots arriving with the FIFO full are dropped and flagged in overflow.
module framebuffer_plot_writer
    import framebuffer_plot_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input logic                      i_clock,
    input logic                      i_reset,
    framebuffer_plot_writer_if.slave fb
);
    state_t             r_state;
    state_t             w_state_nxt;
    plot_t              w_plot_in;
    plot_t              w_head;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               r_clear_d;
    logic               r_clr_pend;
    logic [COLOR_W-1:0] r_clr_color;
    logic               w_clear_rise;
    logic               w_clr_req;
    logic               w_clr_start;
    logic [COLOR_W-1:0] w_clr_color;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [COLOR_W-1:0] r_mem_data;
    logic               w_mem_we_nxt;
    logic [ADDR_W-1:0]  w_mem_addr_nxt;
    logic [COLOR_W-1:0] w_mem_data_nxt;
    logic               r_overflow;

    assign w_plot_in = '{x: fb.xCoordinate, y: fb.yCoordinate, color: fb.colorToDraw};

`ifdef PLOT_BOUNDS_CHECK_EN
    logic w_in_bounds;
    logic r_oob_drop;

    assign w_in_bounds = (fb.xCoordinate < X_W'(SCREEN_W)) && (fb.yCoordinate < Y_W'(SCREEN_H));
    assign w_push      = fb.plot & w_in_bounds;

    always_ff @(posedge i_clock) begin
        if (i_reset)                        r_oob_drop <= 1'b0;
        else if (fb.plot && !w_in_bounds)   r_oob_drop <= 1'b1;
    end
    assign fb.oob_drop = r_oob_drop;
`else
    assign w_push      = fb.plot;
    assign fb.oob_drop = 1'b0;
`endif

    framebuffer_plot_writer_plot_fifo #(
        .WIDTH ($bits(plot_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_push     (w_push),
        .i_push_dat (w_plot_in),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // A clear edge seen while writing plots is held until the FSM is back in IDLE.
    assign w_clear_rise = fb.clear & ~r_clear_d;
    assign w_clr_req    = r_clr_pend | w_clear_rise;
    assign w_clr_color  = w_clear_rise ? fb.clear_color : r_clr_color;

    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_clr_start    = 1'b0;
        w_mem_we_nxt   = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_data_nxt = r_mem_data;
        unique case (r_state)
            IDLE: begin
                if (w_clr_req) begin
                    w_clr_start    = 1'b1;
                    w_state_nxt    = CLEAR;
                    w_mem_we_nxt   = 1'b1;
                    w_mem_addr_nxt = '0;
                    w_mem_data_nxt = w_clr_color;
                end else if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_state_nxt    = WRITE;
                    w_mem_we_nxt   = 1'b1;
                    w_mem_addr_nxt = pixel_addr(w_head.x, w_head.y);
                    w_mem_data_nxt = w_head.color;
                end
            end
            WRITE: begin
                if (!w_clr_req && !w_empty) begin
                    w_pop          = 1'b1;
                    w_mem_we_nxt   = 1'b1;
                    w_mem_addr_nxt = pixel_addr(w_head.x, w_head.y);
                    w_mem_data_nxt = w_head.color;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CLEAR: begin
                // The registered address doubles as the sweep counter.
                if (r_mem_addr == ADDR_W'(NUM_PIXELS - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_mem_we_nxt   = 1'b1;
                    w_mem_addr_nxt = r_mem_addr + ADDR_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_clear_d   <= 1'b0;
            r_clr_pend  <= 1'b0;
            r_clr_color <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mem_we   <= w_mem_we_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_data <= w_mem_data_nxt;
            r_clear_d  <= fb.clear;
            if (w_clr_start) begin
                r_clr_pend <= 1'b0;
            end else if (w_clear_rise && r_state != CLEAR) begin
                r_clr_pend <= 1'b1;
            end
            if (w_clear_rise && r_state != CLEAR) begin
                r_clr_color <= fb.clear_color;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign fb.mem_we   = r_mem_we;
    assign fb.mem_addr = r_mem_addr;
    assign fb.mem_data = r_mem_data;
    assign fb.overflow = r_overflow;
    assign fb.busy     = (r_state != IDLE) | ~w_empty;

endmodule

// File: tb/tb_framebuffer_plot_writer.sv
// Scoreboard bench for framebuffer_plot_writer; honours PLOT_BOUNDS_CHECK_EN when defined.
// Expected writes are queued at stimulus time and consumed by an independent monitor.
module tb_framebuffer_plot_writer;
    import framebuffer_plot_writer_pkg::*;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    framebuffer_plot_writer_if fb();

    framebuffer_plot_writer #(.FIFO_DEPTH(4)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .fb      (fb)
    );

    wr_t                exp_q[$];
    int                 checks      = 0;
    int                 errors      = 0;
    int                 writes_seen = 0;
    bit                 exp_oob     = 1'b0;
    logic [COLOR_W-1:0] palette [8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_addr(input int x, input int y);
        return (y * SCREEN_W + x) % (1 << ADDR_W);
    endfunction

    function automatic bit on_screen(input int x, input int y);
        return (x < SCREEN_W) && (y < SCREEN_H);
    endfunction

    // Plot issued while the writer is free to drain: never overflows.
    task automatic send_plot(input int x, input int y, input int c);
        fb.plot        = 1'b1;
        fb.xCoordinate = X_W'(x);
        fb.yCoordinate = Y_W'(y);
        fb.colorToDraw = COLOR_W'(c);
`ifdef PLOT_BOUNDS_CHECK_EN
        if (!on_screen(x, y)) exp_oob = 1'b1;
        else                  exp_q.push_back('{model_addr(x, y), c});
`else
        exp_q.push_back('{model_addr(x, y), c});
`endif
        @(posedge clk); #1;
        fb.plot = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fb.busy && n < limit);
        check(name, int'(fb.busy), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_flags(input string tag, input int ovf);
        check({tag, "_overflow"}, int'(fb.overflow), ovf);
        check({tag, "_oob_drop"}, int'(fb.oob_drop), int'(exp_oob));
    endtask

    // Monitor: every write the DUT presents must match the head of the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (fb.mem_we === 1'b1) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got write addr=%0d data=%0d, expected no write",
                             fb.mem_addr, fb.mem_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", int'(fb.mem_addr), e.addr);
                    check("wr_data", int'(fb.mem_data), e.data);
                end
            end
        end
    end

    initial begin
        repeat (98000) @(posedge clk);
        $display("FAIL watchdog: got no end of test, expected finish within 98000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        int held;
        int x, y, c;

        palette = '{BLACK, BLUE, GREEN, CYAN, RED, MAGENTA, YELLOW, WHITE};
        fb.plot        = 1'b0;
        fb.xCoordinate = '0;
        fb.yCoordinate = '0;
        fb.colorToDraw = '0;
        fb.clear       = 1'b0;
        fb.clear_color = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mem_we",   int'(fb.mem_we),   0);
        check("rst_mem_addr", int'(fb.mem_addr), 0);
        check("rst_mem_data", int'(fb.mem_data), 0);
        check("rst_busy",     int'(fb.busy),     0);
        check_flags("rst", 0);
        @(posedge clk); #1;

        // Single plot: write appears in the second cycle after the accepting edge.
        send_plot(5, 2, RED);
        @(negedge clk);
        check("lat_c1_we", int'(fb.mem_we), 0);
        @(negedge clk);
        check("lat_c2_we",   int'(fb.mem_we),   1);
        check("lat_c2_addr", int'(fb.mem_addr), 645);
        check("lat_c2_data", int'(fb.mem_data), 4);
        @(negedge clk);
        check("lat_busy_after", int'(fb.busy), 0);
        @(posedge clk); #1;

        // Four back-to-back plots drain at one write per clock.
        for (int i = 0; i < 4; i++) send_plot(10 + i, 20 + i, palette[i + 1]);
        wait_idle("b2b_idle", 40);
        check_flags("b2b", 0);

        // Random stream with random gaps, some coordinates off-screen.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(15) == 0) begin
                x = $urandom_range(511);
                y = $urandom_range(255);
            end else begin
                x = $urandom_range(SCREEN_W - 1);
                y = $urandom_range(SCREEN_H - 1);
            end
            send_plot(x, y, palette[$urandom_range(7)]);
            repeat ($urandom_range(2)) begin @(posedge clk); #1; end
        end
        wait_idle("rand_idle", 100);
        check_flags("rand", 0);

        // Full clear; plots arriving mid-sweep queue up (FIFO holds 4) and land afterwards.
        base           = writes_seen;
        fb.clear       = 1'b1;
        fb.clear_color = BLUE;
        for (int i = 0; i < NUM_PIXELS; i++) exp_q.push_back('{i, int'(BLUE)});
        @(posedge clk); #1;
        fb.clear = 1'b0;
        @(negedge clk);
        check("clear_busy", int'(fb.busy), 1);
        repeat (100) begin @(posedge clk); #1; end
        fb.clear       = 1'b1;
        fb.clear_color = WHITE;
        @(posedge clk); #1;
        fb.clear = 1'b0;
        held = 0;
        for (int k = 0; k < 6; k++) begin
            x = (k == 0) ? SCREEN_W - 1 : $urandom_range(SCREEN_W - 1);
            y = (k == 0) ? SCREEN_H - 1 : $urandom_range(SCREEN_H - 1);
            c = (k == 0) ? int'(YELLOW) : int'(palette[$urandom_range(7)]);
            fb.plot        = 1'b1;
            fb.xCoordinate = X_W'(x);
            fb.yCoordinate = Y_W'(y);
            fb.colorToDraw = COLOR_W'(c);
            if (held < 4) begin
                exp_q.push_back('{model_addr(x, y), c});
                held++;
            end
            @(posedge clk); #1;
        end
        fb.plot = 1'b0;
        @(negedge clk);
        check("clear_overflow_sticky", int'(fb.overflow), 1);
        wait_idle("clear_idle", 80000);
        check("clear_write_count", writes_seen - base, NUM_PIXELS + 4);
        check_flags("clear", 1);

        // Reset after 1000 sweep writes aborts the clear for good.
        base           = writes_seen;
        fb.clear       = 1'b1;
        fb.clear_color = MAGENTA;
        for (int i = 0; i < NUM_PIXELS; i++) exp_q.push_back('{i, int'(MAGENTA)});
        @(posedge clk); #1;
        fb.clear = 1'b0;
        n = 0;
        while ((writes_seen - base) < 1000 && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        check("abort_progress", writes_seen - base, 1000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_oob = 1'b0;
        @(negedge clk);
        check("abort_mem_we",   int'(fb.mem_we),   0);
        check("abort_busy",     int'(fb.busy),     0);
        check("abort_mem_addr", int'(fb.mem_addr), 0);
        check_flags("abort", 0);
        base = writes_seen;
        repeat (200) @(negedge clk);
        check("abort_no_writes", writes_seen - base, 0);
        @(posedge clk); #1;

        // Just past the right edge of the screen.
        send_plot(SCREEN_W, 0, GREEN);
        wait_idle("oob_idle", 20);
        check_flags("oob", 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
